pll_init_seq: RTL and testbench

Parametrised PLL bring-up and lock supervisor, successor to the fixed per-PLL init wrapper. Runs on the always-on init clock; drives the PLL reset and charge-pump and loop-filter settings; qualifies the asynchronous PLL lock; retries on lock timeout; re-acquires after lock loss; reports a sticky failure. Sits between the board reset and each Gowin PLL instance, and its `lock_o` gates downstream reset release.

---
 rtl/pll_init_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_init_seq.sv | 175 +++++++++++++++++
 tb/tb_pll_init_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_init_pkg.sv
// Shared state encoding and elaboration-time helpers for the PLL init sequencer.
package pll_init_pkg;

   typedef enum logic [2:0] {
      StHold,
      StWaitLock,
      StStable,
      StLocked,
      StFail
   } pll_init_state_e;

   function automatic logic [5:0] icpsel_base(input int unsigned multi);
      if (multi >= 32) begin
         return 6'd8;
      end else if (multi >= 16) begin
         return 6'd16;
      end else begin
         return 6'd32;
      end
   endfunction

   function automatic logic [2:0] lpfres_base(input int unsigned multi);
      return (multi >= 16) ? 3'd2 : 3'd4;
   endfunction

   function automatic int unsigned us_to_cycles(input int unsigned us,
                                                input int unsigned period_ns);
      return (us * 1000) / period_ns;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/pll_init_seq.sv
// PLL bring-up and lock supervisor: reset hold, lock qualification, retry and relock.
// Define PLL_INIT_SEQ_SWEEP_EN to step ICPSEL by ICP_STEP on every retry.
module pll_init_seq
   import pll_init_pkg::*;
#(
   parameter int unsigned CLK_PERIOD_NS   = 20,
   parameter int unsigned MULTI_FAC       = 16,
   parameter int unsigned RST_US          = 10,
   parameter int unsigned LOCK_TIMEOUT_US = 500,
   parameter int unsigned STABLE_CYCLES   = 256,
   parameter int unsigned MAX_RETRIES     = 4,
   parameter int unsigned ICP_STEP        = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       restart_i,
   input  logic       pll_lock_i,
   output logic       pll_rst_o,
   output logic [5:0] icpsel_o,
   output logic [2:0] lpfres_o,
   output logic       lock_o,
   output logic       fail_o,
   output logic [7:0] relock_cnt_o
);

   localparam int unsigned RstCyc = us_to_cycles(RST_US, CLK_PERIOD_NS);
   localparam int unsigned ToCyc  = us_to_cycles(LOCK_TIMEOUT_US, CLK_PERIOD_NS);
   localparam int unsigned MaxCyc = max3(RstCyc, ToCyc, STABLE_CYCLES);
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   // The counter holds "cycles remaining minus one" so each phase lasts exactly N cycles.
   localparam logic [CntW-1:0] RstLoad    = CntW'(RstCyc - 1);
   localparam logic [CntW-1:0] ToLoad     = CntW'(ToCyc - 1);
   localparam logic [CntW-1:0] StableLoad = CntW'(STABLE_CYCLES - 1);

   localparam logic [5:0] IcpselBase = icpsel_base(MULTI_FAC);
   localparam logic [2:0] LpfresBase = lpfres_base(MULTI_FAC);
   localparam logic [3:0] RetryMax   = 4'(MAX_RETRIES);

`ifdef PLL_INIT_SEQ_SWEEP_EN
   localparam bit SweepEn = 1'b1;
`else
   localparam bit SweepEn = 1'b0;
`endif
   localparam int unsigned IcpStepEff = SweepEn ? ICP_STEP : 0;

   pll_init_state_e r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]      r_retry, w_retry_nxt;
   logic [5:0]      r_icpsel, w_icpsel_nxt;
   logic [2:0]      r_lpfres;
   logic [7:0]      r_relock_cnt, w_relock_nxt;
   logic            r_pll_rst, r_lock, r_fail;
   logic            w_lock_s;
   logic [3:0]      w_retry_inc;
   logic [31:0]     w_icp_sum;
   logic [5:0]      w_icp_sweep;

   sync_2ff u_lock_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pll_lock_i),
      .q_o    (w_lock_s)
   );

   assign w_retry_inc = r_retry + 4'd1;
   assign w_icp_sum   = 32'(IcpselBase) + 32'(w_retry_inc) * IcpStepEff;
   assign w_icp_sweep = (w_icp_sum > 32'd63) ? 6'd63 : w_icp_sum[5:0];

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_retry_nxt  = r_retry;
      w_icpsel_nxt = r_icpsel;
      w_relock_nxt = r_relock_cnt;

      unique case (r_state)
         StHold: begin
            if (r_cnt == '0) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = ToLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StWaitLock: begin
            if (w_lock_s) begin
               w_state_nxt = StStable;
               w_cnt_nxt   = StableLoad;
            end else if (r_cnt == '0) begin
               w_retry_nxt = w_retry_inc;
               if (w_retry_inc == RetryMax) begin
                  w_state_nxt = StFail;
               end else begin
                  w_state_nxt  = StHold;
                  w_cnt_nxt    = RstLoad;
                  w_icpsel_nxt = w_icp_sweep;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StStable: begin
            if (!w_lock_s) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = ToLoad;
            end else if (r_cnt == '0) begin
               w_state_nxt = StLocked;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StLocked: begin
            if (!w_lock_s) begin
               w_state_nxt  = StHold;
               w_cnt_nxt    = RstLoad;
               w_retry_nxt  = 4'd0;
               w_icpsel_nxt = IcpselBase;
               if (r_relock_cnt != 8'hFF) begin
                  w_relock_nxt = r_relock_cnt + 8'd1;
               end
            end
         end
         StFail: begin
         end
         default: begin
            w_state_nxt  = StHold;
            w_cnt_nxt    = RstLoad;
            w_retry_nxt  = 4'd0;
            w_icpsel_nxt = IcpselBase;
         end
      endcase

      // Restart overrides any same-cycle transition, including a timeout or lock loss.
      if (restart_i) begin
         w_state_nxt  = StHold;
         w_cnt_nxt    = RstLoad;
         w_retry_nxt  = 4'd0;
         w_icpsel_nxt = IcpselBase;
         w_relock_nxt = r_relock_cnt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= StHold;
         r_cnt        <= RstLoad;
         r_retry      <= 4'd0;
         r_icpsel     <= IcpselBase;
         r_lpfres     <= LpfresBase;
         r_relock_cnt <= 8'd0;
         r_pll_rst    <= 1'b1;
         r_lock       <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_retry      <= w_retry_nxt;
         r_icpsel     <= w_icpsel_nxt;
         r_lpfres     <= LpfresBase;
         r_relock_cnt <= w_relock_nxt;
         r_pll_rst    <= (w_state_nxt == StHold) || (w_state_nxt == StFail);
         r_lock       <= (w_state_nxt == StLocked);
         r_fail       <= (w_state_nxt == StFail);
      end
   end

   assign pll_rst_o    = r_pll_rst;
   assign icpsel_o     = r_icpsel;
   assign lpfres_o     = r_lpfres;
   assign lock_o       = r_lock;
   assign fail_o       = r_fail;
   assign relock_cnt_o = r_relock_cnt;

endmodule

// File: tb/tb_pll_init_seq.sv
// Directed bench for pll_init_seq: bring-up, glitch, lock loss, retry exhaustion, recovery.
module tb_pll_init_seq;

   logic       clk;
   logic       rst_ni;
   logic       restart;
   logic       pll_lock;
   logic       pll_rst;
   logic [5:0] icpsel;
   logic [2:0] lpfres;
   logic       lock;
   logic       fail;
   logic [7:0] relock_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int k;
   int saw_rst;

`ifdef PLL_INIT_SEQ_SWEEP_EN
   localparam logic [5:0] ExpIcp2 = 6'd20;
   localparam logic [5:0] ExpIcp3 = 6'd24;
`else
   localparam logic [5:0] ExpIcp2 = 6'd16;
   localparam logic [5:0] ExpIcp3 = 6'd16;
`endif

   pll_init_seq #(
      .CLK_PERIOD_NS   (20),
      .MULTI_FAC       (16),
      .RST_US          (1),
      .LOCK_TIMEOUT_US (2),
      .STABLE_CYCLES   (8),
      .MAX_RETRIES     (3),
      .ICP_STEP        (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .restart_i    (restart),
      .pll_lock_i   (pll_lock),
      .pll_rst_o    (pll_rst),
      .icpsel_o     (icpsel),
      .lpfres_o     (lpfres),
      .lock_o       (lock),
      .fail_o       (fail),
      .relock_cnt_o (relock_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_ni   = 1'b0;
      restart  = 1'b0;
      pll_lock = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_icpsel", 32'(icpsel), 32'd16);
      chk("rst_lpfres", 32'(lpfres), 32'd2);
      chk("rst_lock", 32'(lock), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      chk("rst_relock", 32'(relock_cnt), 32'd0);

      // Clean bring-up
      rst_ni = 1'b1;
      k = 0;
      while (pll_rst && k < 200) begin
         k++;
         @(negedge clk);
      end
      chk("bringup_hold_len", 32'(k), 32'd50);
      chk("bringup_icpsel", 32'(icpsel), 32'd16);
      chk("bringup_lpfres", 32'(lpfres), 32'd2);
      repeat (20) @(negedge clk);
      chk("bringup_prelock", 32'(lock), 32'd0);
      pll_lock = 1'b1;
      k = 0;
      while (!lock && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("bringup_lock_lat", 32'(k), 32'd11);
      chk("bringup_pll_rst", 32'(pll_rst), 32'd0);
      chk("bringup_fail", 32'(fail), 32'd0);

      // Lock loss in LOCKED
      repeat (5) @(negedge clk);
      pll_lock = 1'b0;
      k = 0;
      while (lock && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("loss_lat", 32'(k), 32'd3);
      chk("loss_pll_rst", 32'(pll_rst), 32'd1);
      chk("loss_relock", 32'(relock_cnt), 32'd1);
      k = 0;
      while (pll_rst && k < 200) begin
         k++;
         @(negedge clk);
      end
      chk("loss_hold_len", 32'(k), 32'd50);
      chk("loss_icpsel", 32'(icpsel), 32'd16);
      pll_lock = 1'b1;
      k = 0;
      while (!lock && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("relock_lat", 32'(k), 32'd11);
      chk("relock_cnt_keep", 32'(relock_cnt), 32'd1);

      // Restart from LOCKED coinciding with lock drop, then glitch during STABLE
      restart  = 1'b1;
      pll_lock = 1'b0;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_relock", 32'(relock_cnt), 32'd1);
      chk("restart_pll_rst", 32'(pll_rst), 32'd1);
      chk("restart_lock", 32'(lock), 32'd0);
      k = 0;
      while (pll_rst && k < 200) begin
         k++;
         @(negedge clk);
      end
      pll_lock = 1'b1;
      repeat (4) @(negedge clk);
      pll_lock = 1'b0;
      repeat (2) @(negedge clk);
      chk("glitch_lock_low", 32'(lock), 32'd0);
      pll_lock = 1'b1;
      k = 0;
      saw_rst = 0;
      while (!lock && k < 50) begin
         @(negedge clk);
         k++;
         if (pll_rst) saw_rst = 1;
      end
      chk("glitch_lock_lat", 32'(k), 32'd11);
      chk("glitch_no_hold", 32'(saw_rst), 32'd0);
      chk("glitch_relock", 32'(relock_cnt), 32'd1);

      // Retry exhaustion with lock held low
      restart  = 1'b1;
      pll_lock = 1'b0;
      k = 0;
      while (!fail && k < 600) begin
         @(negedge clk);
         k++;
         if (k == 1) restart = 1'b0;
         if (k == 101) begin
            chk("try1_icpsel", 32'(icpsel), 32'd16);
            chk("try1_pll_rst", 32'(pll_rst), 32'd0);
         end
         if (k == 176) chk("try2_hold", 32'(pll_rst), 32'd1);
         if (k == 251) begin
            chk("try2_icpsel", 32'(icpsel), 32'(ExpIcp2));
            chk("try2_pll_rst", 32'(pll_rst), 32'd0);
         end
         if (k == 401) begin
            chk("try3_icpsel", 32'(icpsel), 32'(ExpIcp3));
            chk("try3_pll_rst", 32'(pll_rst), 32'd0);
         end
      end
      chk("fail_cycle", 32'(k), 32'd451);
      chk("fail_pll_rst", 32'(pll_rst), 32'd1);
      chk("fail_lock", 32'(lock), 32'd0);
      repeat (10) @(negedge clk);
      chk("fail_sticky", 32'(fail), 32'd1);

      // Restart out of FAIL
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("unfail_fail", 32'(fail), 32'd0);
      chk("unfail_pll_rst", 32'(pll_rst), 32'd1);
      chk("unfail_icpsel", 32'(icpsel), 32'd16);
      chk("unfail_relock", 32'(relock_cnt), 32'd1);
      k = 0;
      while (pll_rst && k < 200) begin
         k++;
         @(negedge clk);
      end
      chk("unfail_hold_len", 32'(k), 32'd50);

      // Asynchronous reset during WAIT_LOCK, sampled before any clock edge
      repeat (5) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_pll_rst", 32'(pll_rst), 32'd1);
      chk("arst_relock", 32'(relock_cnt), 32'd0);
      chk("arst_icpsel", 32'(icpsel), 32'd16);
      chk("arst_lpfres", 32'(lpfres), 32'd2);
      chk("arst_lock", 32'(lock), 32'd0);
      chk("arst_fail", 32'(fail), 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      k = 0;
      while (pll_rst && k < 200) begin
         k++;
         @(negedge clk);
      end
      chk("arst_hold_len", 32'(k), 32'd50);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
